// File: rtl/xmit_pkg.sv
// Shared constants and state encoding for the frame transmit controller.
package xmit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DEST     = 3'd3,
        ST_SRC      = 3'd4,
        ST_TYPE     = 3'd5,
        ST_PAYLOAD  = 3'd6
    } xmit_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD0;
    localparam logic [7:0] EOT_BYTE      = 8'h04;
    localparam logic [7:0] BCAST_ADDR    = 8'h2A;

    function automatic logic is_bcast(input logic [7:0] addr);
        return (addr == BCAST_ADDR);
    endfunction

endpackage

// File: rtl/frame_buf_fifo.sv
// First-word-fall-through payload buffer; an extra pointer bit separates full from empty.
module frame_buf_fifo
    import xmit_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; push and pop in the same cycle both advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/frame_xmit_controller.sv
// Buffers UART payload bytes and emits framed bytes (preamble, SFD, header, payload) to a byte transmitter.
module frame_xmit_controller
    import xmit_pkg::*;
#(
    parameter int FIFO_DEPTH     = 64,
    parameter int PREAMBLE_BYTES = 2
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mac_addr,
    input  logic [7:0] dest_addr,
    input  logic [7:0] type_byte,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       send_frame,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_rdy,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [2:0] PRE_LAST = 3'(PREAMBLE_BYTES - 1);

    xmit_state_e r_state;
    logic [7:0]  r_tx_data;
    logic [7:0]  r_dest;
    logic [7:0]  r_src;
    logic [7:0]  r_type;
    logic [7:0]  r_pay_cnt;
    logic [2:0]  r_pre_cnt;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_overflow;

    logic        w_eot;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic        w_accept;
    logic        w_start;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_fifo_dout;
    logic [AW:0] w_count;

    assign w_eot    = din_valid && (din == EOT_BYTE);
    assign w_push   = din_valid && !w_eot && !w_full;
    assign w_drop   = din_valid && !w_eot && w_full;
    assign w_accept = r_tx_valid && tx_rdy;
    assign w_pop    = w_accept && (r_state == ST_PAYLOAD);
    assign w_start  = (r_state == ST_IDLE) && (((send_frame || w_eot) && !w_empty) || w_full);

    frame_buf_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (din),
        .dout  (w_fifo_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Payload bytes come straight from the FIFO head, which only moves on acceptance.
    assign tx_data  = (r_state == ST_PAYLOAD) ? w_fifo_dout : r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign full     = w_full;
    assign overflow = r_overflow;

    // Frame sequencer; the next byte is loaded in the cycle the current one is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_dest     <= 8'h00;
            r_src      <= 8'h00;
            r_type     <= 8'h00;
            r_pay_cnt  <= 8'h00;
            r_pre_cnt  <= 3'd0;
        end else begin
            r_overflow <= w_drop;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_PREAMBLE;
                        r_tx_data  <= PREAMBLE_BYTE;
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_pre_cnt  <= 3'd0;
                        r_pay_cnt  <= 8'(w_count);
                        r_dest     <= dest_addr;
                        r_src      <= mac_addr;
                        r_type     <= type_byte;
                    end
                end
                ST_PREAMBLE: begin
                    if (w_accept) begin
                        if (r_pre_cnt == PRE_LAST) begin
                            r_state   <= ST_SFD;
                            r_tx_data <= SFD_BYTE;
                        end else begin
                            r_pre_cnt <= r_pre_cnt + 3'd1;
                        end
                    end
                end
                ST_SFD: begin
                    if (w_accept) begin
                        r_state   <= ST_DEST;
                        r_tx_data <= r_dest;
                    end
                end
                ST_DEST: begin
                    if (w_accept) begin
                        r_state   <= ST_SRC;
                        r_tx_data <= r_src;
                    end
                end
                ST_SRC: begin
                    if (w_accept) begin
                        r_state   <= ST_TYPE;
                        r_tx_data <= r_type;
                    end
                end
                ST_TYPE: begin
                    if (w_accept) begin
                        r_state   <= ST_PAYLOAD;
                        r_tx_data <= 8'h00;
                    end
                end
                ST_PAYLOAD: begin
                    // A snapshot of 0 stands for 256 bytes and counts down through 255.
                    if (w_accept) begin
                        if (r_pay_cnt == 8'd1) begin
                            r_state    <= ST_IDLE;
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_pay_cnt  <= 8'd0;
                        end else begin
                            r_pay_cnt  <= r_pay_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_data  <= 8'h00;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_xmit_controller.md
FRAME_XMIT_CONTROLLER -- requirements
Module: frame_xmit_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, payload buffer depth in bytes (power of 2, 4..256).
REQ-002 SHALL have parameter PREAMBLE_BYTES, default 2, number of 0x55 preamble bytes per frame (1..7).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-low.
REQ-005 SHALL have port mac_addr  input  8  own address, sent as source byte.
REQ-006 SHALL have port dest_addr  input  8  destination byte (0x2A = broadcast).
REQ-007 SHALL have port type_byte  input  8  frame type byte.
REQ-008 SHALL have port din  input  8  payload byte from the UART receiver.
REQ-009 SHALL have port din_valid  input  1  one-cycle strobe, din valid.
REQ-010 SHALL have port send_frame  input  1  one-cycle request to transmit buffered payload.
REQ-011 SHALL have port tx_data  output  8  byte to the Manchester byte transmitter.
REQ-012 SHALL have port tx_valid  output  1  tx_data valid.
REQ-013 SHALL have port tx_rdy  input  1  byte transmitter can accept a byte.
REQ-014 SHALL have port busy  output  1  high from frame start until the last byte is accepted.
REQ-015 SHALL have port full  output  1  payload buffer full.
REQ-016 SHALL have port overflow  output  1  one-cycle pulse when a byte is dropped.

Function
REQ-017 SHALL store din in the FIFO when din_valid=1, din!=0x04, and the FIFO is not full.
REQ-018 SHALL treat din=0x04 (EOT) with din_valid=1 as send_frame; 0x04 SHALL NOT be stored.
REQ-019 SHALL drop din and pulse overflow for one cycle when din_valid=1 arrives while the FIFO is full.
REQ-020 SHALL start a frame from IDLE on send_frame or EOT when the FIFO is non-empty, or automatically when full=1.
REQ-021 SHALL ignore send_frame/EOT while the FIFO is empty or while busy=1.
REQ-022 SHALL snapshot the FIFO count into an 8-bit payload counter at frame start; bytes written later belong to the next frame.
REQ-023 SHALL sequence states IDLE -> PREAMBLE (PREAMBLE_BYTES x 0x55) -> SFD (0xD0) -> DEST (dest_addr) -> SRC (mac_addr) -> TYPE (type_byte) -> PAYLOAD (snapshot-count bytes) -> IDLE.
REQ-024 SHALL latch dest_addr and type_byte at frame start; input changes mid-frame SHALL NOT affect the frame.
REQ-025 SHALL transfer one byte in each cycle with tx_valid=1 and tx_rdy=1, then advance counters/state.
REQ-026 SHALL hold tx_data stable while tx_valid=1 and tx_rdy=0.
REQ-027 SHALL keep tx_valid asserted back-to-back across all states until the final payload byte is accepted.
REQ-028 SHALL pop the FIFO exactly in the cycle a PAYLOAD byte is accepted; simultaneous push and pop SHALL both take effect, count unchanged.
REQ-029 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; full/empty SHALL derive from an extra pointer bit.
REQ-030 SHALL deassert busy and tx_valid the cycle after the last payload byte is accepted; an auto-start SHALL wait for the next cycle in IDLE.
REQ-031 SHALL present a FIFO_DEPTH payload as a single frame, the 8-bit counter representing 256 as 0 only when FIFO_DEPTH=256.

Reset
REQ-032 SHALL, while rst=0, set state IDLE, tx_valid=0, tx_data=0x00, busy=0, overflow=0, FIFO empty (full=0), counters 0.
REQ-033 SHALL, on reset mid-frame, abandon the frame and discard all buffered payload; tx_valid SHALL be 0 the cycle after rst samples low.

Structure
REQ-034 SHALL place the state enum, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD0, EOT_BYTE 0x04, and BCAST_ADDR 0x2A in shared package xmit_pkg.
REQ-035 SHALL implement the payload buffer as sub-module frame_buf_fifo (push, pop, din, dout, count, full, empty), first-word-fall-through.

Verification
REQ-036 SHALL test: push 0x41,0x42,0x43, send_frame, tx_rdy=1 -> tx sequence 55 55 D0 dest mac type 41 42 43, busy 9 cycles.
REQ-037 SHALL test: push 0x31 then 0x04 -> frame sent with payload 0x31 only, no 0x04 on tx_data.
REQ-038 SHALL test: tx_rdy toggling 1/0 every cycle -> identical byte order, tx_data stable whenever tx_rdy=0.
REQ-039 SHALL test: push 64 bytes with tx_rdy=0, then a 65th -> full=1, overflow one-cycle pulse, auto frame of 64 payload bytes.
REQ-040 SHALL test: push 2, send_frame, push 2 during PREAMBLE -> first frame carries 2 bytes, second send_frame yields the next 2.
REQ-041 SHALL test: rst=0 during PAYLOAD -> tx_valid=0 next cycle, full=0, subsequent send_frame ignored (FIFO empty).
